hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl_if.sv | 22 ++
 rtl/hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - ID-stage instruction in, forwarding selects and interlock out
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      ifid_ir;
  logic             ext_stall;
  logic [1:0]       fa;
  logic [1:0]       fb;
  logic             stall;
  logic             bubble;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output ifid_ir, ext_stall,
    input  fa, fb, stall, bubble, stall_count
  );

  modport slave (
    input  ifid_ir, ext_stall,
    output fa, fb, stall, bubble, stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding select generation and load-use interlock for the 5-stage core
module hazard_ctrl #(
  parameter logic [5:0] OP_ALU  = 6'd0,
  parameter logic [5:0] OP_J    = 6'd2,
  parameter logic [5:0] OP_JAL  = 6'd3,
  parameter logic [5:0] OP_ADDI = 6'd8,
  parameter logic [5:0] OP_LW   = 6'd35,
  parameter logic [5:0] OP_SW   = 6'd43,
  parameter int         CNT_W   = 16
) (
  input  logic         clock,
  input  logic         resetn,
  hazard_ctrl_if.slave hif
);

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unused_ir;

  assign op        = hif.ifid_ir[31:26];
  assign rs        = hif.ifid_ir[25:21];
  assign rt        = hif.ifid_ir[20:16];
  assign rd        = hif.ifid_ir[15:11];
  assign unused_ir = ^hif.ifid_ir[10:0];

  logic       rs_used;
  logic       rt_used;
  logic       id_ld;
  logic       id_wr;
  logic [4:0] id_dst;

  always_comb begin
    rs_used = 1'b0;
    rt_used = 1'b0;
    id_ld   = 1'b0;
    id_dst  = 5'd0;
    case (op)
      OP_ALU: begin
        rs_used = 1'b1;
        rt_used = 1'b1;
        id_dst  = rd;
      end
      OP_ADDI: begin
        rs_used = 1'b1;
        id_dst  = rt;
      end
      OP_LW: begin
        rs_used = 1'b1;
        id_dst  = rt;
        id_ld   = 1'b1;
      end
      OP_SW: begin
        rs_used = 1'b1;
        rt_used = 1'b1;
      end
      OP_JAL:  id_dst = 5'd31;
      OP_J:    ;
      default: ;
    endcase
  end

  // r0 is hardwired, so a write to it never creates a dependency
  assign id_wr = (id_dst != 5'd0);

  logic [4:0]       ex_dst;
  logic             ex_wr;
  logic             ex_ld;
  logic [4:0]       mem_dst;
  logic             mem_wr;
  logic [1:0]       fa_q;
  logic [1:0]       fb_q;
  logic [CNT_W-1:0] cnt_q;

  function automatic logic [1:0] fwd_sel(
    input logic       used,
    input logic [4:0] src,
    input logic       e_wr,
    input logic [4:0] e_dst,
    input logic       m_wr,
    input logic [4:0] m_dst
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (used && src != 5'd0) begin
      if (e_wr && e_dst == src)
        sel = 2'b10;
      else if (m_wr && m_dst == src)
        sel = 2'b01;
    end
    return sel;
  endfunction

  logic [1:0] fa_next;
  logic [1:0] fb_next;
  logic       rs_hit;
  logic       rt_hit;
  logic       load_use;
  logic       stall_i;

  assign fa_next  = fwd_sel(rs_used, rs, ex_wr, ex_dst, mem_wr, mem_dst);
  assign fb_next  = fwd_sel(rt_used, rt, ex_wr, ex_dst, mem_wr, mem_dst);

  // A load in EX has no result until after MEM, so a consumer in ID must wait a cycle
  assign rs_hit   = rs_used & (rs == ex_dst);
  assign rt_hit   = rt_used & (rt == ex_dst);
  assign load_use = ex_ld & ex_wr & (rs_hit | rt_hit);
  assign stall_i  = ~hif.ext_stall & load_use;

  assign hif.stall       = stall_i;
  assign hif.bubble      = stall_i;
  assign hif.fa          = fa_q;
  assign hif.fb          = fb_q;
  assign hif.stall_count = cnt_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      ex_dst  <= 5'd0;
      ex_wr   <= 1'b0;
      ex_ld   <= 1'b0;
      mem_dst <= 5'd0;
      mem_wr  <= 1'b0;
      fa_q    <= 2'b00;
      fb_q    <= 2'b00;
      cnt_q   <= '0;
    end else if (!hif.ext_stall) begin
      mem_dst <= ex_dst;
      mem_wr  <= ex_wr;
      if (stall_i) begin
        ex_wr <= 1'b0;
        ex_ld <= 1'b0;
        fa_q  <= 2'b00;
        fb_q  <= 2'b00;
        if (cnt_q != {CNT_W{1'b1}})
          cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        ex_dst <= id_dst;
        ex_wr  <= id_wr;
        ex_ld  <= id_ld;
        fa_q   <= fa_next;
        fb_q   <= fb_next;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl with an instruction-level pipeline model
module tb_hazard_ctrl;
  localparam int SCNT_W = 3;

  logic clock    = 1'b0;
  logic resetn   = 1'b0;
  logic resetn_s = 1'b0;
  int   checks   = 0;
  int   errors   = 0;

  always #5 clock = ~clock;

  hazard_ctrl_if #(.CNT_W(16))     hif ();
  hazard_ctrl_if #(.CNT_W(SCNT_W)) sif ();

  hazard_ctrl #(.CNT_W(16))     dut   (.clock(clock), .resetn(resetn),   .hif(hif));
  hazard_ctrl #(.CNT_W(SCNT_W)) dut_s (.clock(clock), .resetn(resetn_s), .hif(sif));

  // Model keeps the raw instruction words sitting in EX and MEM
  logic [31:0] m_ex_ir;
  logic [31:0] m_mem_ir;
  bit          m_ex_v;
  bit          m_mem_v;
  logic [1:0]  m_fa;
  logic [1:0]  m_fb;
  int          m_cnt;

  function automatic logic [31:0] alu(input int rd, input int rs, input int rt);
    logic [4:0] d, s, t;
    d = rd[4:0]; s = rs[4:0]; t = rt[4:0];
    return {6'd0, s, t, d, 5'd0, 6'd32};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rt, input int rs, input int imm);
    logic [5:0]  o;
    logic [4:0]  s, t;
    logic [15:0] i;
    o = op[5:0]; s = rs[4:0]; t = rt[4:0]; i = imm[15:0];
    return {o, s, t, i};
  endfunction

  function automatic int op_of(input logic [31:0] ir); return int'(ir[31:26]); endfunction
  function automatic int rs_of(input logic [31:0] ir); return int'(ir[25:21]); endfunction
  function automatic int rt_of(input logic [31:0] ir); return int'(ir[20:16]); endfunction
  function automatic int rd_of(input logic [31:0] ir); return int'(ir[15:11]); endfunction

  function automatic bit reads_rs(input logic [31:0] ir);
    int o;
    o = op_of(ir);
    return o == 0 || o == 8 || o == 35 || o == 43;
  endfunction

  function automatic bit reads_rt(input logic [31:0] ir);
    int o;
    o = op_of(ir);
    return o == 0 || o == 43;
  endfunction

  function automatic int dest_of(input logic [31:0] ir);
    case (op_of(ir))
      0:       return rd_of(ir);
      8, 35:   return rt_of(ir);
      3:       return 31;
      default: return 0;
    endcase
  endfunction

  function automatic logic [1:0] m_fwd(input int src, input bit used);
    if (!used || src == 0) return 2'b00;
    if (m_ex_v && dest_of(m_ex_ir) == src) return 2'b10;
    if (m_mem_v && dest_of(m_mem_ir) == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_stall();
    logic [31:0] ir;
    int d;
    ir = hif.ifid_ir;
    if (hif.ext_stall || !m_ex_v || op_of(m_ex_ir) != 35) return 1'b0;
    d = dest_of(m_ex_ir);
    if (d == 0) return 1'b0;
    return (reads_rs(ir) && rs_of(ir) == d) || (reads_rt(ir) && rt_of(ir) == d);
  endfunction

  task automatic set_in(input logic [31:0] ir, input bit es, input bit rn);
    hif.ifid_ir   = ir;
    hif.ext_stall = es;
    resetn        = rn;
    @(negedge clock);
  endtask

  task automatic tick();
    logic [31:0] n_ex_ir, n_mem_ir;
    bit          n_ex_v, n_mem_v, st;
    logic [1:0]  n_fa, n_fb;
    int          n_cnt;
    n_ex_ir = m_ex_ir; n_mem_ir = m_mem_ir; n_ex_v = m_ex_v; n_mem_v = m_mem_v;
    n_fa = m_fa; n_fb = m_fb; n_cnt = m_cnt;
    st = m_stall();
    if (!resetn) begin
      n_ex_v = 1'b0; n_mem_v = 1'b0; n_fa = 2'b00; n_fb = 2'b00; n_cnt = 0;
    end else if (!hif.ext_stall) begin
      n_mem_ir = m_ex_ir;
      n_mem_v  = m_ex_v;
      if (st) begin
        n_ex_v = 1'b0; n_fa = 2'b00; n_fb = 2'b00;
        if (n_cnt < 65535) n_cnt++;
      end else begin
        n_ex_ir = hif.ifid_ir;
        n_ex_v  = 1'b1;
        n_fa    = m_fwd(rs_of(hif.ifid_ir), reads_rs(hif.ifid_ir));
        n_fb    = m_fwd(rt_of(hif.ifid_ir), reads_rt(hif.ifid_ir));
      end
    end
    @(posedge clock);
    #1;
    m_ex_ir = n_ex_ir; m_mem_ir = n_mem_ir; m_ex_v = n_ex_v; m_mem_v = n_mem_v;
    m_fa = n_fa; m_fb = n_fb; m_cnt = n_cnt;
  endtask

  task automatic test_reset();
    set_in(32'd0, 1'b0, 1'b0); tick();
    set_in(32'd0, 1'b0, 1'b1);
    checks++;
    if (hif.fa !== 2'b00 || hif.fb !== 2'b00 || hif.stall !== 1'b0 || hif.bubble !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: fa=%b fb=%b stall=%b bubble=%b want 00 00 0 0", hif.fa, hif.fb, hif.stall, hif.bubble);
    end
    checks++;
    if (hif.stall_count !== 16'd0) begin
      errors++; $display("FAIL reset_count: got %0d want 0", hif.stall_count);
    end
    tick();
  endtask

  task automatic test_ex_fwd();
    set_in(alu(3, 1, 2), 1'b0, 1'b1); tick();
    set_in(alu(4, 3, 5), 1'b0, 1'b1);
    checks++;
    if (hif.stall !== 1'b0) begin errors++; $display("FAIL ex_fwd_stall: got %b want 0", hif.stall); end
    tick();
    set_in(32'd0, 1'b0, 1'b1);
    checks++;
    if (hif.fa !== 2'b10 || hif.fb !== 2'b00) begin
      errors++; $display("FAIL ex_fwd_sel: fa=%b fb=%b want 10 00", hif.fa, hif.fb);
    end
    tick();
  endtask

  task automatic test_mem_fwd();
    set_in(alu(3, 1, 2), 1'b0, 1'b1); tick();
    set_in(32'd0, 1'b0, 1'b1);       tick();
    set_in(alu(6, 7, 3), 1'b0, 1'b1); tick();
    set_in(32'd0, 1'b0, 1'b1);
    checks++;
    if (hif.fa !== 2'b00 || hif.fb !== 2'b01) begin
      errors++; $display("FAIL mem_fwd_sel: fa=%b fb=%b want 00 01", hif.fa, hif.fb);
    end
    tick();
    set_in(alu(3, 1, 2), 1'b0, 1'b1); tick();
    set_in(alu(3, 1, 2), 1'b0, 1'b1); tick();
    set_in(alu(6, 3, 7), 1'b0, 1'b1); tick();
    set_in(32'd0, 1'b0, 1'b1);
    checks++;
    if (hif.fa !== 2'b10 || hif.fb !== 2'b00) begin
      errors++; $display("FAIL fwd_priority: fa=%b fb=%b want 10 00", hif.fa, hif.fb);
    end
    tick();
  endtask

  task automatic test_load_use();
    set_in(32'd0, 1'b0, 1'b0); tick();
    set_in(itype(35, 5, 1, 0), 1'b0, 1'b1); tick();
    set_in(alu(6, 5, 2), 1'b0, 1'b1);
    checks++;
    if (hif.stall !== 1'b1 || hif.bubble !== 1'b1) begin
      errors++; $display("FAIL load_use_stall: stall=%b bubble=%b want 1 1", hif.stall, hif.bubble);
    end
    tick();
    set_in(alu(6, 5, 2), 1'b0, 1'b1);
    checks++;
    if (hif.stall !== 1'b0 || hif.fa !== 2'b00 || hif.stall_count !== 16'd1) begin
      errors++; $display("FAIL load_use_bubble: stall=%b fa=%b count=%0d want 0 00 1", hif.stall, hif.fa, hif.stall_count);
    end
    tick();
    set_in(32'd0, 1'b0, 1'b1);
    checks++;
    if (hif.fa !== 2'b01 || hif.fb !== 2'b00) begin
      errors++; $display("FAIL load_use_fwd: fa=%b fb=%b want 01 00", hif.fa, hif.fb);
    end
    tick();
  endtask

  task automatic test_r0_and_store();
    set_in(alu(0, 1, 2), 1'b0, 1'b1); tick();
    set_in(alu(4, 0, 0), 1'b0, 1'b1); tick();
    set_in(32'd0, 1'b0, 1'b1);
    checks++;
    if (hif.fa !== 2'b00 || hif.fb !== 2'b00) begin
      errors++; $display("FAIL r0_sel: fa=%b fb=%b want 00 00", hif.fa, hif.fb);
    end
    tick();
    set_in(itype(8, 7, 1, 5), 1'b0, 1'b1); tick();
    set_in(itype(43, 7, 2, 0), 1'b0, 1'b1); tick();
    set_in(32'd0, 1'b0, 1'b1);
    checks++;
    if (hif.fa !== 2'b00 || hif.fb !== 2'b10) begin
      errors++; $display("FAIL sw_fwd: fa=%b fb=%b want 00 10", hif.fa, hif.fb);
    end
    tick();
  endtask

  task automatic test_ext_stall();
    set_in(32'd0, 1'b0, 1'b0); tick();
    set_in(alu(1, 2, 3), 1'b0, 1'b1); tick();
    set_in(itype(35, 5, 1, 0), 1'b0, 1'b1); tick();
    for (int i = 0; i < 3; i++) begin
      set_in(alu(6, 5, 2), 1'b1, 1'b1);
      checks++;
      if (hif.stall !== 1'b0 || hif.bubble !== 1'b0 || hif.fa !== 2'b10 || hif.fb !== 2'b00 || hif.stall_count !== 16'd0) begin
        errors++; $display("FAIL ext_freeze[%0d]: stall=%b bubble=%b fa=%b fb=%b count=%0d want 0 0 10 00 0",
                           i, hif.stall, hif.bubble, hif.fa, hif.fb, hif.stall_count);
      end
      tick();
    end
    set_in(alu(6, 5, 2), 1'b0, 1'b1);
    checks++;
    if (hif.stall !== 1'b1) begin errors++; $display("FAIL ext_release_stall: got %b want 1", hif.stall); end
    tick();
    set_in(alu(6, 5, 2), 1'b0, 1'b1);
    checks++;
    if (hif.stall !== 1'b0 || hif.stall_count !== 16'd1) begin
      errors++; $display("FAIL ext_single_interlock: stall=%b count=%0d want 0 1", hif.stall, hif.stall_count);
    end
    tick();
    set_in(32'd0, 1'b0, 1'b1);
    checks++;
    if (hif.fa !== 2'b01 || hif.fb !== 2'b00) begin
      errors++; $display("FAIL ext_after_fwd: fa=%b fb=%b want 01 00", hif.fa, hif.fb);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    set_in(32'd0, 1'b0, 1'b0); tick();
    set_in(itype(35, 5, 1, 0), 1'b0, 1'b1); tick();
    set_in(itype(35, 6, 5, 0), 1'b0, 1'b1);
    checks++;
    if (hif.stall !== 1'b1) begin errors++; $display("FAIL b2b_first_stall: got %b want 1", hif.stall); end
    tick();
    set_in(itype(35, 6, 5, 0), 1'b0, 1'b1); tick();
    set_in(alu(7, 6, 2), 1'b0, 1'b1);
    checks++;
    if (hif.stall !== 1'b1 || hif.fa !== 2'b01) begin
      errors++; $display("FAIL b2b_second_stall: stall=%b fa=%b want 1 01", hif.stall, hif.fa);
    end
    tick();
    set_in(alu(7, 6, 2), 1'b0, 1'b1); tick();
    set_in(itype(35, 8, 1, 0), 1'b0, 1'b1);
    checks++;
    if (hif.fa !== 2'b01) begin errors++; $display("FAIL b2b_add_fwd: fa=%b want 01", hif.fa); end
    tick();
    set_in(itype(35, 8, 2, 4), 1'b0, 1'b1);
    checks++;
    if (hif.stall !== 1'b0) begin errors++; $display("FAIL same_reg_loads: stall=%b want 0", hif.stall); end
    tick();
    set_in(32'd0, 1'b0, 1'b1);
    checks++;
    if (hif.stall_count !== 16'd2) begin errors++; $display("FAIL b2b_count: got %0d want 2", hif.stall_count); end
    tick();
  endtask

  task automatic test_reset_interlock();
    set_in(itype(35, 5, 1, 0), 1'b0, 1'b1); tick();
    set_in(alu(6, 5, 2), 1'b0, 1'b0);
    checks++;
    if (hif.stall !== 1'b1 || hif.stall_count !== 16'(m_cnt)) begin
      errors++; $display("FAIL pre_reset: stall=%b count=%0d want 1 %0d", hif.stall, hif.stall_count, m_cnt);
    end
    tick();
    set_in(alu(6, 5, 2), 1'b0, 1'b1);
    checks++;
    if (hif.fa !== 2'b00 || hif.fb !== 2'b00 || hif.stall !== 1'b0 || hif.stall_count !== 16'd0) begin
      errors++; $display("FAIL reset_cancel: fa=%b fb=%b stall=%b count=%0d want 00 00 0 0", hif.fa, hif.fb, hif.stall, hif.stall_count);
    end
    tick();
    set_in(32'd0, 1'b0, 1'b1);
    checks++;
    if (hif.fa !== 2'b00) begin errors++; $display("FAIL reset_redecode: fa=%b want 00", hif.fa); end
    tick();
  endtask

  task automatic test_saturate();
    int exp_cnt;
    logic exp_st;
    sif.ifid_ir   = itype(35, 5, 5, 0);
    sif.ext_stall = 1'b0;
    resetn_s      = 1'b0;
    set_in(32'd0, 1'b0, 1'b1); tick();
    resetn_s = 1'b1;
    for (int k = 0; k < 20; k++) begin
      set_in(32'd0, 1'b0, 1'b1);
      exp_st  = ((k % 2) == 1);
      exp_cnt = (k / 2 > 7) ? 7 : k / 2;
      checks++;
      if (sif.stall !== exp_st || sif.stall_count !== SCNT_W'(exp_cnt)) begin
        errors++; $display("FAIL saturate[%0d]: stall=%b count=%0d want %b %0d", k, sif.stall, sif.stall_count, exp_st, exp_cnt);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [31:0] ir;
    bit es, rn, st;
    int o;
    int ops[7] = '{0, 2, 3, 8, 35, 43, 13};
    ir = 32'd0;
    set_in(32'd0, 1'b0, 1'b0); tick();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        o  = ops[$urandom_range(0, 6)];
        ir = {o[5:0], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 11'($urandom)};
      end
      es = ($urandom_range(0, 7) == 0);
      rn = ($urandom_range(0, 49) != 0);
      set_in(ir, es, rn);
      st = m_stall();
      checks++;
      if (hif.stall !== st || hif.bubble !== st) begin
        errors++; $display("FAIL rnd_stall[%0d]: stall=%b bubble=%b want %b", i, hif.stall, hif.bubble, st);
      end
      checks++;
      if (hif.fa !== m_fa || hif.fb !== m_fb) begin
        errors++; $display("FAIL rnd_sel[%0d]: fa=%b fb=%b want %b %b", i, hif.fa, hif.fb, m_fa, m_fb);
      end
      checks++;
      if (hif.stall_count !== 16'(m_cnt)) begin
        errors++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, hif.stall_count, m_cnt);
      end
      tick();
    end
  endtask

  initial begin
    hif.ifid_ir = 32'd0; hif.ext_stall = 1'b0;
    sif.ifid_ir = 32'd0; sif.ext_stall = 1'b0;
    m_ex_ir = 32'd0; m_mem_ir = 32'd0; m_ex_v = 1'b0; m_mem_v = 1'b0;
    m_fa = 2'b00; m_fb = 2'b00; m_cnt = 0;
    @(posedge clock);
    #1;
    test_reset();
    test_ex_fwd();
    test_mem_fwd();
    test_load_use();
    test_r0_and_store();
    test_ext_stall();
    test_back_to_back();
    test_reset_interlock();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
